// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Handles load-use bubbles, taken-branch flushes and mul/div occupancy.
// Inputs: clk, reset (sync, active-high), F/D source regs, D/X load/md/rd,
//   md_ready, branch_taken.
// Outputs: PC/F/D/D/X/X/M/M/W write enables, F/D/D/X/X/M flushes,
//   md_start, md_busy, md_timeout.
// Optional: define MD_WATCHDOG_EN to bound MD_RUN to MD_CYCLES cycles.
module pipeline_stall_ctrl #(
  parameter int MD_CYCLES = 34,
  parameter int CNT_W     = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] fd_rs1,
  input  logic [4:0] fd_rs2,
  input  logic       fd_uses_rs2,
  input  logic       dx_is_load,
  input  logic [4:0] dx_rd,
  input  logic       dx_is_md,
  input  logic       md_ready,
  input  logic       branch_taken,
  output logic       pc_we,
  output logic       fd_we,
  output logic       dx_we,
  output logic       xm_we,
  output logic       mw_we,
  output logic       fd_flush,
  output logic       dx_flush,
  output logic       xm_flush,
  output logic       md_start,
  output logic       md_busy,
  output logic       md_timeout
);

  if ((2 ** CNT_W) <= MD_CYCLES) begin : gBadCfg
    $error("CNT_W too narrow for MD_CYCLES");
  end

  typedef enum logic [1:0] {
    IDLE,
    MD_RUN,
    MD_DONE
  } state_t;

  state_t           state;
  state_t           stateNext;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext;
  logic             loadUse;
  logic             wdFire;

  assign loadUse = dx_is_load && (dx_rd != 5'd0) &&
                   ((dx_rd == fd_rs1) ||
                    (fd_uses_rs2 && (dx_rd == fd_rs2)));

`ifdef MD_WATCHDOG_EN
  localparam logic [CNT_W-1:0] WdLast = CNT_W'(MD_CYCLES - 1);

  logic timeoutQ;

  assign wdFire = (state == MD_RUN) && !md_ready &&
                  (cnt == WdLast);

  always_ff @(posedge clk) begin
    if (reset) begin
      timeoutQ <= 1'b0;
    end else if (wdFire) begin
      timeoutQ <= 1'b1;
    end
  end

  // Masked during reset so the flag reads 0 in the reset cycle itself.
  assign md_timeout = timeoutQ & ~reset;
`else
  assign wdFire     = 1'b0;
  assign md_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    state <= stateNext;
    cnt   <= cntNext;
  end

  always_comb begin
    pc_we     = 1'b1;
    fd_we     = 1'b1;
    dx_we     = 1'b1;
    xm_we     = 1'b1;
    mw_we     = 1'b1;
    fd_flush  = 1'b0;
    dx_flush  = 1'b0;
    xm_flush  = 1'b0;
    md_start  = 1'b0;
    md_busy   = 1'b0;
    stateNext = state;
    cntNext   = cnt;
    if (reset) begin
      pc_we     = 1'b0;
      fd_we     = 1'b0;
      dx_we     = 1'b0;
      xm_we     = 1'b0;
      mw_we     = 1'b0;
      stateNext = IDLE;
      cntNext   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (dx_is_md) begin
            // Freeze the front end; X/M gets nops while the unit works.
            md_start  = 1'b1;
            pc_we     = 1'b0;
            fd_we     = 1'b0;
            dx_we     = 1'b0;
            xm_flush  = 1'b1;
            stateNext = MD_RUN;
            cntNext   = '0;
          end else if (branch_taken) begin
            fd_flush = 1'b1;
            dx_flush = 1'b1;
          end else if (loadUse) begin
            pc_we    = 1'b0;
            fd_we    = 1'b0;
            dx_flush = 1'b1;
          end
        end
        MD_RUN: begin
          md_busy  = 1'b1;
          pc_we    = 1'b0;
          fd_we    = 1'b0;
          dx_we    = 1'b0;
          xm_flush = 1'b1;
          if (cnt != '1) begin
            cntNext = cnt + 1'b1;
          end
          if (md_ready || wdFire) begin
            stateNext = MD_DONE;
          end
        end
        MD_DONE: begin
          // Result latches into X/M; hazard inputs are ignored here.
          stateNext = IDLE;
        end
        default: begin
          stateNext = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed vector bench for pipeline_stall_ctrl.
// Table-driven IDLE hazard cases plus reset, mul/div and watchdog sequences.
module tb_pipeline_stall_ctrl;

  localparam int MD_CYCLES = 34;
  localparam int CNT_W     = 6;

  // {pc,fd,dx,xm,mw, fdF,dxF,xmF, start,busy,timeout}
  localparam logic [10:0] ZERO   = 11'b00000_000_000;
  localparam logic [10:0] ALLON  = 11'b11111_000_000;
  localparam logic [10:0] STALL  = 11'b00111_010_000;
  localparam logic [10:0] BRANCH = 11'b11111_110_000;
  localparam logic [10:0] START  = 11'b00011_001_100;
  localparam logic [10:0] BUSY   = 11'b00011_001_010;
  localparam logic [10:0] DONETO = 11'b11111_000_001;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] fd_rs1;
  logic [4:0] fd_rs2;
  logic       fd_uses_rs2;
  logic       dx_is_load;
  logic [4:0] dx_rd;
  logic       dx_is_md;
  logic       md_ready;
  logic       branch_taken;
  logic       pc_we, fd_we, dx_we, xm_we, mw_we;
  logic       fd_flush, dx_flush, xm_flush;
  logic       md_start, md_busy, md_timeout;
  logic [10:0] act;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(
    .MD_CYCLES(MD_CYCLES),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fd_rs1(fd_rs1),
    .fd_rs2(fd_rs2),
    .fd_uses_rs2(fd_uses_rs2),
    .dx_is_load(dx_is_load),
    .dx_rd(dx_rd),
    .dx_is_md(dx_is_md),
    .md_ready(md_ready),
    .branch_taken(branch_taken),
    .pc_we(pc_we),
    .fd_we(fd_we),
    .dx_we(dx_we),
    .xm_we(xm_we),
    .mw_we(mw_we),
    .fd_flush(fd_flush),
    .dx_flush(dx_flush),
    .xm_flush(xm_flush),
    .md_start(md_start),
    .md_busy(md_busy),
    .md_timeout(md_timeout)
  );

  assign act = {pc_we, fd_we, dx_we, xm_we, mw_we,
                fd_flush, dx_flush, xm_flush,
                md_start, md_busy, md_timeout};

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        uses2;
    logic        isLoad;
    logic [4:0]  rd;
    logic        ready;
    logic        branch;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string nm, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%b exp=%b", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    fd_rs1       = '0;
    fd_rs2       = '0;
    fd_uses_rs2  = 1'b0;
    dx_is_load   = 1'b0;
    dx_rd        = '0;
    dx_is_md     = 1'b0;
    md_ready     = 1'b0;
    branch_taken = 1'b0;
  endtask

  task automatic setLoadUse();
    dx_is_load  = 1'b1;
    dx_rd       = 5'd5;
    fd_rs2      = 5'd5;
    fd_uses_rs2 = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout act=%b", act);
    $fatal(1, "bench time limit");
  end

  initial begin
    int n;
    vecs[0] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, ALLON};
    vecs[1] = '{5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, STALL};
    vecs[2] = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, ALLON};
    vecs[3] = '{5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, ALLON};
    vecs[4] = '{5'd7, 5'd2, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, STALL};
    vecs[5] = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, BRANCH};
    vecs[6] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, BRANCH};
    vecs[7] = '{5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, ALLON};
    vecs[8] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, ALLON};

    clearIn();
    reset = 1'b1;
    step();
    check("reset_c1", ZERO);
    dx_is_md = 1'b1;
    #1;
    check("reset_c2_md", ZERO);
    step();
    reset    = 1'b0;
    dx_is_md = 1'b0;
    #1;
    check("post_reset", ALLON);
    step();

    for (int i = 0; i < 9; i++) begin
      fd_rs1       = vecs[i].rs1;
      fd_rs2       = vecs[i].rs2;
      fd_uses_rs2  = vecs[i].uses2;
      dx_is_load   = vecs[i].isLoad;
      dx_rd        = vecs[i].rd;
      md_ready     = vecs[i].ready;
      branch_taken = vecs[i].branch;
      #1;
      check($sformatf("vec%0d", i), vecs[i].exp);
      step();
    end
    clearIn();

    setLoadUse();
    #1;
    check("lu_stall", STALL);
    step();
    dx_is_load = 1'b0;
    #1;
    check("lu_one_bubble", ALLON);
    step();
    clearIn();

    dx_is_md     = 1'b1;
    md_ready     = 1'b1;
    branch_taken = 1'b1;
    #1;
    check("md_start", START);
    step();
    md_ready     = 1'b0;
    branch_taken = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        branch_taken = 1'b1;
        setLoadUse();
      end
      if (i == 9) md_ready = 1'b1;
      #1;
      check($sformatf("md_busy%0d", i), BUSY);
      step();
    end
    md_ready     = 1'b0;
    branch_taken = 1'b1;
    #1;
    check("md_done", ALLON);
    step();
    check("b2b_start", START);
    branch_taken = 1'b0;
    dx_is_load   = 1'b0;
    step();
    check("b2b_busy0", BUSY);
    step();
    check("b2b_busy1", BUSY);
    reset = 1'b1;
    #1;
    check("mid_run_reset", ZERO);
    step();
    reset    = 1'b0;
    dx_is_md = 1'b0;
    #1;
    check("after_reset_idle", ALLON);
    step();
    check("still_idle", ALLON);
    clearIn();

    dx_is_md = 1'b1;
    #1;
    check("wd_start", START);
    step();
    n = 0;
`ifdef MD_WATCHDOG_EN
    while ((act === BUSY) && (n < 100)) begin
      n++;
      step();
    end
    checks++;
    if (n != MD_CYCLES) begin
      errors++;
      $display("FAIL wd_len act=%0d exp=%0d", n, MD_CYCLES);
    end
    check("wd_done", DONETO);
    dx_is_md = 1'b0;
    step();
    check("wd_sticky", DONETO);
    step();
    check("wd_sticky2", DONETO);
    reset = 1'b1;
    #1;
    check("wd_reset", ZERO);
    step();
    reset = 1'b0;
    #1;
    check("wd_cleared", ALLON);
`else
    while ((act === BUSY) && (n < 2 * MD_CYCLES)) begin
      n++;
      step();
    end
    checks++;
    if (n != 2 * MD_CYCLES) begin
      errors++;
      $display("FAIL nowd_len act=%0d exp=%0d", n, 2 * MD_CYCLES);
    end
    check("nowd_busy", BUSY);
    reset = 1'b1;
    #1;
    check("nowd_reset", ZERO);
    step();
    reset    = 1'b0;
    dx_is_md = 1'b0;
    #1;
    check("nowd_idle", ALLON);
`endif
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
